// File: rtl/window_sum_pipe.sv
// Four-stage 3x3 window reducer: plain sum, rounded mean, Gaussian 1-2-1 mean,
// or centre pass-through, with a single global stall driven by the output handshake.
module window_sum_pipe #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = DATA_W + 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] c1,
  input  logic [DATA_W-1:0] c2,
  input  logic [DATA_W-1:0] c3,
  input  logic [DATA_W-1:0] c4,
  input  logic [DATA_W-1:0] c5,
  input  logic [DATA_W-1:0] c6,
  input  logic [DATA_W-1:0] c7,
  input  logic [DATA_W-1:0] c8,
  input  logic [DATA_W-1:0] c9,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SUM_W-1:0]  sum,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int IW = DATA_W + 4;

  // pos: 0 = corner, 1 = edge, 2 = centre. Mode 3 zeroes everything but the
  // centre so the centre value rides the same adder tree unchanged.
  function automatic logic [IW-1:0] weigh(input logic [DATA_W-1:0] px,
                                          input logic [1:0]        m,
                                          input logic [1:0]        pos);
    logic [IW-1:0] v;
    v = IW'(px);
    case (m)
      2'd2:    weigh = v << pos;
      2'd3:    weigh = (pos == 2'd2) ? v : '0;
      default: weigh = v;
    endcase
  endfunction

  function automatic logic [SUM_W-1:0] normalise(input logic [IW-1:0] t,
                                                 input logic [1:0]  m);
    logic [IW-1:0] r;
    case (m)
      2'd1:    r = (t + IW'(4)) / IW'(9);
      2'd2:    r = (t + IW'(8)) >> 4;
      default: r = t;
    endcase
    return SUM_W'(r);
  endfunction

  logic          en;
  logic          vld_p1, vld_p2, vld_p3;
  logic [1:0]    mode_p1, mode_p2, mode_p3;
  logic [IW-1:0] a_p1, b_p1, c_p1, d_p1, e_p1;
  logic [IW-1:0] x_p2, y_p2, z_p2;
  logic [IW-1:0] t_p3;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst_n;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
    end else if (en) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      out_valid <= vld_p3;
      if (vld_p3) sum <= normalise(t_p3, mode_p3);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      // S1: weighting and five partial sums
      mode_p1 <= mode;
      a_p1    <= weigh(c1, mode, 2'd0) + weigh(c2, mode, 2'd1);
      b_p1    <= weigh(c3, mode, 2'd0) + weigh(c4, mode, 2'd1);
      c_p1    <= weigh(c6, mode, 2'd1) + weigh(c7, mode, 2'd0);
      d_p1    <= weigh(c8, mode, 2'd1) + weigh(c9, mode, 2'd0);
      e_p1    <= weigh(c5, mode, 2'd2);
      // S2: three partial sums
      mode_p2 <= mode_p1;
      x_p2    <= a_p1 + b_p1;
      y_p2    <= c_p1 + d_p1;
      z_p2    <= e_p1;
      // S3: window total
      mode_p3 <= mode_p2;
      t_p3    <= x_p2 + y_p2 + z_p2;
    end
  end

endmodule

// File: tb/tb_window_sum_pipe.sv
// Bench for window_sum_pipe: directed vectors, mode interleave, backpressure,
// reset with windows in flight, and random traffic against a queue-based model.
module tb_window_sum_pipe;

  localparam int DATA_W = 8;
  localparam int SUM_W  = DATA_W + 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] cw [9];
  logic [1:0]        mode;
  logic              in_valid, in_ready;
  logic [SUM_W-1:0]  sum;
  logic              out_valid, out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q [$];

  always #5 clk = ~clk;

  window_sum_pipe #(.DATA_W(DATA_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .c1(cw[0]), .c2(cw[1]), .c3(cw[2]), .c4(cw[3]), .c5(cw[4]),
    .c6(cw[5]), .c7(cw[6]), .c8(cw[7]), .c9(cw[8]),
    .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .out_valid(out_valid), .out_ready(out_ready)
  );

  // pixels c1..c9, mode, expected result
  int tv [8][11] = '{
    '{255, 255, 255, 255, 255, 255, 255, 255, 255, 0, 2295},
    '{  1,   2,   3,   4,   5,   6,   7,   8,   9, 1,    5},
    '{255, 255, 255, 255, 255, 255, 255, 255, 255, 1,  255},
    '{  0,   0,   0,   0,   4,   0,   0,   0,   0, 1,    0},
    '{100, 100, 100, 100, 100, 100, 100, 100, 100, 2,  100},
    '{  0,   0,   0,   0,  16,   0,   0,   0,   0, 2,    4},
    '{  8,   0,   0,   0,   0,   0,   0,   0,   0, 2,    1},
    '{  1,   2,   3,   4, 200,   6,   7,   8,   9, 3,  200}
  };

  function automatic int model();
    int s, ws;
    int w [9];
    w = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    s = 0;
    ws = 0;
    for (int i = 0; i < 9; i++) begin
      s  += int'(cw[i]);
      ws += w[i] * int'(cw[i]);
    end
    case (mode)
      2'd0:    return s;
      2'd1:    return (s + 4) / 9;
      2'd2:    return (ws + 8) / 16;
      default: return int'(cw[4]);
    endcase
  endfunction

  task automatic rand_window();
    int pick;
    pick = $urandom_range(0, 7);
    for (int i = 0; i < 9; i++) begin
      if (pick == 0)      cw[i] = 8'hFF;
      else if (pick == 1) cw[i] = 8'h00;
      else                cw[i] = 8'($urandom_range(0, 255));
    end
    mode = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++;
    if (sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %0d want 0", sum); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    int k;
    logic [SUM_W-1:0] e;
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 9; i++) cw[i] = 8'(tv[v][i]);
      mode = 2'(tv[v][9]);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 8) begin
        @(posedge clk);
        #1;
        k++;
      end
      n_checks++;
      if (!out_valid || k != 3) begin
        n_fail++;
        $display("FAIL dir%0d_latency: got %0d cycles (valid=%0b) want 3", v, k, out_valid);
      end
      e = SUM_W'(tv[v][10]);
      n_checks++;
      if (sum !== e) begin n_fail++; $display("FAIL dir%0d_sum: got %0d want %0d", v, sum, e); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_interleave();
    int expv [4];
    logic [SUM_W-1:0] e;
    expv = '{81, 9, 9, 9};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) cw[i] = 8'd9;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      e = SUM_W'(expv[j]);
      n_checks++;
      if (out_valid !== 1'b1 || sum !== e) begin
        n_fail++;
        $display("FAIL interleave%0d: got valid=%0b sum=%0d want valid=1 sum=%0d", j, out_valid, sum, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    int cyc, sent, got;
    logic acc, prev_stall;
    logic [SUM_W-1:0] prev_sum, e;
    cyc = 0; sent = 0; got = 0; acc = 1'b0; prev_stall = 1'b0; prev_sum = '0;
    exp_q.delete();
    in_valid = 1'b0;
    while (got < 6 && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc <= 9);
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < 6) begin rand_window(); in_valid = 1'b1; end
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || sum !== prev_sum) begin
          n_fail++;
          $display("FAIL bp_hold c%0d: got valid=%0b sum=%0d want valid=1 sum=%0d", cyc, out_valid, sum, prev_sum);
        end
      end
      if (out_valid && !out_ready) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %0b want 0", cyc, in_ready); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra c%0d: got sum=%0d want no result", cyc, sum);
        end else begin
          e = SUM_W'(exp_q.pop_front());
          if (sum !== e) begin n_fail++; $display("FAIL bp_order%0d: got %0d want %0d", got, sum, e); end
          got++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin exp_q.push_back(model()); sent++; end
      prev_stall = out_valid && !out_ready;
      prev_sum = sum;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got != 6) begin n_fail++; $display("FAIL bp_count: got %0d results want 6", got); end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_inflight();
    int seen;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_window();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || sum !== '0) begin
      n_fail++;
      $display("FAIL rst_flight: got valid=%0b sum=%0d want valid=0 sum=0", out_valid, sum);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_flight_ready: got %0b want 0", in_ready); end
    rst_n = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_ghosts: got %0d results want 0", seen); end
  endtask

  task automatic test_random();
    int cyc, sent, got;
    logic acc, prev_stall;
    logic [SUM_W-1:0] prev_sum, e;
    cyc = 0; sent = 0; got = 0; acc = 1'b0; prev_stall = 1'b0; prev_sum = '0;
    exp_q.delete();
    in_valid = 1'b0;
    while (got < 200 && cyc < 2000) begin
      out_ready = (sent >= 200) || ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        if (sent < 200 && $urandom_range(0, 3) != 0) begin rand_window(); in_valid = 1'b1; end
        else in_valid = 1'b0;
      end
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || sum !== prev_sum) begin
          n_fail++;
          $display("FAIL rnd_hold c%0d: got valid=%0b sum=%0d want valid=1 sum=%0d", cyc, out_valid, sum, prev_sum);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra c%0d: got sum=%0d want no result", cyc, sum);
        end else begin
          e = SUM_W'(exp_q.pop_front());
          if (sum !== e) begin n_fail++; $display("FAIL rnd_sum%0d: got %0d want %0d", got, sum, e); end
          got++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin exp_q.push_back(model()); sent++; end
      prev_stall = out_valid && !out_ready;
      prev_sum = sum;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got != 200) begin n_fail++; $display("FAIL rnd_count: got %0d results want 200", got); end
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    mode = 2'd0;
    for (int i = 0; i < 9; i++) cw[i] = '0;
    test_reset();
    test_directed();
    test_interleave();
    test_backpressure();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/window_sum_pipe.md
WINDOW_SUM_PIPE -- requirements
Module: window_sum_pipe

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits; legal range 4..12.
REQ-002 Parameter SUM_W, default DATA_W+4, result width; SUM_W < DATA_W+4 is illegal.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst_n  input  1  reset; the legacy port name is retained; synchronous, active-high (1 = reset).
REQ-005 c1..c9  input  DATA_W each  3x3 window pixels, row-major; c5 is the centre.
REQ-006 mode  input  2  operation: 0 = plain sum, 1 = mean, 2 = Gaussian 1-2-1 weighted mean, 3 = pass centre.
REQ-007 in_valid  input  1  window and mode are valid this cycle.
REQ-008 in_ready  output  1  block accepts the window this cycle.
REQ-009 sum  output  SUM_W  result; zero-extended when the result is narrower than SUM_W.
REQ-010 out_valid  output  1  sum is valid.
REQ-011 out_ready  input  1  downstream accepts sum this cycle.

Function
REQ-012 Transfer in: occurs when in_valid=1 and in_ready=1; mode is captured with the data and travels with it.
REQ-013 Transfer out: occurs when out_valid=1 and out_ready=1.
REQ-014 Pipeline: 4 registered stages.
- S1: applies weights and forms 5 partial sums.
- S2: reduces to 3 partial sums.
- S3: reduces to 1 total.
- S4: normalises.
REQ-015 Stall rule: all stages advance together on enable = !out_valid | out_ready; in_ready = enable, with no combinational path from in_valid to in_ready.
REQ-016 Bubbles: each stage carries a valid bit; empty stages propagate as bubbles and do not assert out_valid.
REQ-017 Latency: an accepted window yields out_valid exactly 4 cycles later if out_ready stays 1; throughput is 1 window/cycle.
REQ-018 Mode 0: sum = c1+...+c9, exact, max 9*(2^DATA_W-1).
REQ-019 Mode 1: sum = floor((S+4)/9), where S is the plain sum; round-half-up, exact for all inputs; a constant-multiply approximation is allowed only if bit-exact.
REQ-020 Mode 2 weights: corners x1, edges x2, centre x4 (total weight 16).
REQ-021 Mode 2: sum = (W+8)>>4, where W is the weighted sum; max W = 16*(2^DATA_W-1) fits SUM_W.
REQ-022 Mode 3: sum = c5, delayed 4 cycles.
REQ-023 No internal overflow: every intermediate is at least DATA_W+4 bits wide.
REQ-024 Stall behaviour: while out_valid=1 and out_ready=0, sum and out_valid hold stable and no stage changes.
REQ-025 Simultaneous in/out transfer on a full pipeline: both occur in the same cycle, with no bubble inserted and no data lost.
REQ-026 Stall while in_valid=0: inputs are ignored and no result is created.

Reset
REQ-027 With rst_n=1 at a rising edge, all stage valid bits are cleared, out_valid=0, and sum=0 on the next cycle.
REQ-028 During reset, in_ready=0; in_ready=1 on the first cycle after rst_n returns to 0.
REQ-029 Reset mid-operation discards all in-flight windows; none appear at the output after reset.
REQ-030 Data registers other than sum need not be reset.

Verification
REQ-031 Mode 0: c1..c9=255, DATA_W=8, out_ready=1 -> sum=2295 (0x8F7), out_valid 4 cycles after accept.
REQ-032 Mode 1: c1..c9 = 1,2,...,9 -> sum=5; c1..c9 all 255 -> sum=255; eight 0 with c5=4 -> sum=0 (S=4, floor(8/9)=0).
REQ-033 Mode 2: c1..c9=100 -> sum=100; c5=16, others 0 -> sum=4; c1=8, others 0 -> sum=1.
REQ-034 Backpressure: stream 6 windows with out_ready=0 from cycle 5 to 9.
- Required: in_ready=0 during the stall.
- Required: sum and out_valid stay stable during the stall.
- Required: all 6 results emerge in order with no loss or duplication.
REQ-035 Reset: assert rst_n with 3 windows in flight -> out_valid=0, sum=0 next cycle, and none of the 3 results appear afterwards.
REQ-036 Mode interleave: back-to-back windows with mode 0,1,2,3 and identical data c1..c9=9 -> sums 81, 9, 9, 9 on consecutive cycles.
